// File: rtl/my_mem_pkg.sv
// rtl/my_mem_pkg.sv - shared sizing constants and address type for the small register memories
package my_mem_pkg;

  localparam int ADDR_W        = 2;
  localparam int DEPTH         = 4;
  localparam int OCC_W         = 3;
  localparam int DEFAULT_WIDTH = 16;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/my_dmux_4_way.sv
// rtl/my_dmux_4_way.sv - routes one strobe to one of four outputs chosen by a 2-bit select
module my_dmux_4_way
  import my_mem_pkg::*;
(
  input  logic             in_i,
  input  addr_t            sel_i,
  output logic [DEPTH-1:0] out_o
);

  // One-hot fan-out of the strobe; all outputs low when the strobe is low.
  always_comb begin
    out_o        = '0;
    out_o[sel_i] = in_i;
  end

endmodule

// File: rtl/my_register.sv
// rtl/my_register.sv - WIDTH-bit load-enabled register with asynchronous active-low reset
module my_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next state: capture d_i when loaded, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = d_i;
    end
  end

  // State register; reset clears it regardless of clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/my_ram4.sv
// rtl/my_ram4.sv - 4-entry register memory with per-entry valid bits, clear and occupancy count
module my_ram4
  import my_mem_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  addr_t            address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] wr_en;
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d;
  logic             valid_d;

  my_dmux_4_way u_dmux (
    .in_i  (load),
    .sel_i (address),
    .out_o (wr_en)
  );

  // Clear wins over load: every entry is loaded with zero and invalidated.
  always_comb begin
    data_d  = clear ? '0 : in;
    valid_d = ~clear;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    my_register #(.WIDTH(WIDTH)) u_data (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (wr_en[i] | clear),
      .d_i    (data_d),
      .q_o    (data_q[i])
    );

    my_register #(.WIDTH(1)) u_valid (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (wr_en[i] | clear),
      .d_i    (valid_d),
      .q_o    (valid_q[i])
    );
  end

  // Combinational read of the addressed entry; writes show up only after the edge.
  always_comb begin
    out       = data_q[address];
    out_valid = valid_q[address];
  end

  logic [1:0] pair_lo;
  logic [1:0] pair_hi;

  // Two-level popcount of the valid bits.
  always_comb begin
    pair_lo   = {1'b0, valid_q[0]} + {1'b0, valid_q[1]};
    pair_hi   = {1'b0, valid_q[2]} + {1'b0, valid_q[3]};
    occupancy = {1'b0, pair_lo} + {1'b0, pair_hi};
  end

endmodule

// File: tb/tb_my_ram4.sv
// tb/tb_my_ram4.sv - directed table-driven bench for my_ram4
module tb_my_ram4;
  import my_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  addr_t       address;
  logic        clear;
  logic [15:0] out;
  logic        out_valid;
  logic [2:0]  occupancy;

  int tests;
  int failed;

  my_ram4 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .load      (load),
    .address   (address),
    .clear     (clear),
    .out       (out),
    .out_valid (out_valid),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic        clear;
    logic [1:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_out;
    logic        exp_valid;
    logic [2:0]  exp_occ;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clocked operation, then read back the same address with strobes low.
  task automatic apply_vec(input int i);
    @(negedge clk);
    load    = vecs[i].load;
    clear   = vecs[i].clear;
    address = vecs[i].addr;
    in      = vecs[i].din;
    @(posedge clk);
    #1;
    load  = 1'b0;
    clear = 1'b0;
    #1;
    check($sformatf("vec%0d out", i), {16'h0, out}, {16'h0, vecs[i].exp_out});
    check($sformatf("vec%0d valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_valid});
    check($sformatf("vec%0d occ", i), {29'h0, occupancy}, {29'h0, vecs[i].exp_occ});
  endtask

  logic [15:0] fill_val [4];
  logic [15:0] model [4];
  logic        model_v [4];

  initial begin
    tests  = 0;
    failed = 0;

    //           load  clr  addr  din       out       v     occ
    vecs[0] = '{1'b1, 1'b0, 2'd0, 16'h1234, 16'h1234, 1'b1, 3'd1};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 16'hABCD, 16'hABCD, 1'b1, 3'd2};
    vecs[2] = '{1'b1, 1'b0, 2'd2, 16'h0001, 16'h0001, 1'b1, 3'd3};
    vecs[3] = '{1'b1, 1'b0, 2'd3, 16'hFFFF, 16'hFFFF, 1'b1, 3'd4};
    vecs[4] = '{1'b1, 1'b1, 2'd1, 16'h7777, 16'h0000, 1'b0, 3'd0};
    vecs[5] = '{1'b1, 1'b0, 2'd3, 16'hBEEF, 16'hBEEF, 1'b1, 3'd1};
    vecs[6] = '{1'b1, 1'b0, 2'd0, 16'h2222, 16'h2222, 1'b1, 3'd2};
    vecs[7] = '{1'b1, 1'b0, 2'd1, 16'h4321, 16'h4321, 1'b1, 3'd1};

    fill_val[0] = 16'h1234;
    fill_val[1] = 16'hABCD;
    fill_val[2] = 16'h0001;
    fill_val[3] = 16'hFFFF;

    rst_n   = 1'b0;
    in      = 16'hFFFF;
    load    = 1'b1;
    clear   = 1'b0;
    address = 2'd0;
    #12;
    check("reset out", {16'h0, out}, 32'h0);
    check("reset valid", {31'h0, out_valid}, 32'h0);
    check("reset occ", {29'h0, occupancy}, 32'h0);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;

    // Fill all four entries; occupancy steps 1..4.
    for (int i = 0; i < 4; i++) apply_vec(i);

    for (int a = 0; a < 4; a++) begin
      address = a[1:0];
      #1;
      check($sformatf("fill read a%0d", a), {16'h0, out}, {16'h0, fill_val[a]});
      check($sformatf("fill valid a%0d", a), {31'h0, out_valid}, 32'h1);
    end

    // Read-during-write returns the old value until the edge.
    @(negedge clk);
    address = 2'd2;
    in      = 16'h5555;
    load    = 1'b1;
    #1;
    check("rdw before edge", {16'h0, out}, 32'h0001);
    @(posedge clk);
    #1;
    load = 1'b0;
    check("rdw after edge", {16'h0, out}, 32'h5555);
    check("rdw occ", {29'h0, occupancy}, 32'h4);

    // Clear beats load, then a single isolated write.
    apply_vec(4);
    apply_vec(5);
    for (int a = 0; a < 3; a++) begin
      address = a[1:0];
      #1;
      check($sformatf("iso out a%0d", a), {16'h0, out}, 32'h0);
      check($sformatf("iso valid a%0d", a), {31'h0, out_valid}, 32'h0);
    end

    // Hold: strobes low for 10 cycles with random data on in.
    for (int a = 0; a < 4; a++) begin
      model[a]   = (a == 3) ? 16'hBEEF : 16'h0000;
      model_v[a] = (a == 3);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      address = c[1:0];
      in      = 16'($urandom);
      load    = 1'b0;
      clear   = 1'b0;
      #1;
      check($sformatf("hold out c%0d", c), {16'h0, out}, {16'h0, model[c % 4]});
      check($sformatf("hold valid c%0d", c), {31'h0, out_valid}, {31'h0, model_v[c % 4]});
      @(posedge clk);
      #1;
      check($sformatf("hold occ c%0d", c), {29'h0, occupancy}, 32'h1);
    end

    // Asynchronous reset mid-cycle while a write is pending.
    apply_vec(6);
    @(negedge clk);
    address = 2'd0;
    in      = 16'hFFFF;
    load    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out", {16'h0, out}, 32'h0);
    check("async rst valid", {31'h0, out_valid}, 32'h0);
    check("async rst occ", {29'h0, occupancy}, 32'h0);
    @(posedge clk);
    #1;
    check("rst held occ", {29'h0, occupancy}, 32'h0);
    address = 2'd3;
    #1;
    check("rst a3 out", {16'h0, out}, 32'h0);
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;

    // First edge after reset release writes normally.
    apply_vec(7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
